// File: rtl/bin_to_seg_bank.sv
// Sequential double-dabble binary-to-BCD converter feeding eight registered 7-segment digits.
// Optional macro LEADING_ZERO_BLANK_EN blanks digits above the most significant non-zero digit.
module bin_to_seg_bank #(
  parameter int unsigned IN_WIDTH = 27
) (
  input  logic                CLK100MHZ,
  input  logic                reset,
  input  logic [IN_WIDTH-1:0] in_value,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                done,
  output logic                overflow,
  output logic [6:0]          CA7,
  output logic [6:0]          CA6,
  output logic [6:0]          CA5,
  output logic [6:0]          CA4,
  output logic [6:0]          CA3,
  output logic [6:0]          CA2,
  output logic [6:0]          CA1,
  output logic [6:0]          CA0
);

  localparam int unsigned CntW     = $clog2(IN_WIDTH + 1);
  localparam logic [31:0] MaxValue = 32'd99_999_999;
  localparam logic [6:0]  SegBlank = 7'b1111111;
  localparam logic [6:0]  SegDash  = 7'b1111110;

  typedef enum logic [1:0] {StIdle, StShift, StLoad} state_e;

  state_e                state_q, state_d;
  logic [IN_WIDTH-1:0]   bin_q, bin_d;
  logic [31:0]           bcd_q, bcd_d;
  logic [31:0]           bcd_adj;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  ovf_pend_q, ovf_pend_d;
  logic                  overflow_q, overflow_d;
  logic                  done_q, done_d;
  logic [7:0][6:0]       ca_q, ca_d;
  logic [7:0][6:0]       seg_num;
`ifdef LEADING_ZERO_BLANK_EN
  logic                  seen_nz;
`endif

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = SegDash;
    endcase
    return s;
  endfunction

  // State register
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StShift;
      StShift: if (cnt_q == CntW'(1)) state_d = StLoad;
      StLoad:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready = (state_q == StIdle);
  end

  // Add-3 correction on every nibble before each shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 8; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    seg_num = '0;
`ifdef LEADING_ZERO_BLANK_EN
    seen_nz = 1'b0;
`endif
    for (int i = 7; i >= 0; i--) begin
      seg_num[i] = seg_enc(bcd_q[4*i +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
      if (bcd_q[4*i +: 4] != 4'd0) seen_nz = 1'b1;
      if (!seen_nz && (i != 0)) seg_num[i] = SegBlank;
`endif
    end
  end

  always_comb begin
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    overflow_d = overflow_q;
    ca_d       = ca_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          bin_d      = in_value;
          bcd_d      = '0;
          cnt_d      = CntW'(IN_WIDTH);
          ovf_pend_d = ({{(32-IN_WIDTH){1'b0}}, in_value} > MaxValue);
        end
      end
      StShift: begin
        bcd_d = {bcd_adj[30:0], bin_q[IN_WIDTH-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q - CntW'(1);
      end
      StLoad: begin
        ca_d       = ovf_pend_q ? {8{SegDash}} : seg_num;
        overflow_d = ovf_pend_q;
        done_d     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      ca_q       <= {8{SegBlank}};
    end else begin
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      ca_q       <= ca_d;
    end
  end

  assign done     = done_q;
  assign overflow = overflow_q;
  assign CA7      = ca_q[7];
  assign CA6      = ca_q[6];
  assign CA5      = ca_q[5];
  assign CA4      = ca_q[4];
  assign CA3      = ca_q[3];
  assign CA2      = ca_q[2];
  assign CA1      = ca_q[1];
  assign CA0      = ca_q[0];

endmodule
